// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Brief    : Shared types and constants for the BCD-to-binary converter:
//             FSM state encoding and BCD digit constants.
//  Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  // Width of one packed BCD digit.
  localparam int c_digit_w = 4;

  // Largest legal BCD digit value.
  localparam logic [c_digit_w-1:0] c_max_digit = 4'd9;

  // A nibble at or above this value after a right shift carries an extra
  // tens bit that must be corrected.
  localparam logic [c_digit_w-1:0] c_nib_thresh = 4'd8;
  localparam logic [c_digit_w-1:0] c_nib_adj    = 4'd3;

  // Converter FSM; one state per clock cycle.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_nibble_sub3.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_nibble_sub3
//  Brief    : Combinational per-digit correction for reverse double-dabble:
//             a nibble >= 8 is reduced by 3 (4-bit, no borrow out).
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_nibble_sub3
  import bcd_pkg::*;
(
  input  logic [c_digit_w-1:0] i_nib,
  output logic [c_digit_w-1:0] o_nib
);

  // Remove the excess left behind when a tens bit shifted into this digit.
  always_comb begin
    o_nib = i_nib;
    if (i_nib >= c_nib_thresh) begin
      o_nib = i_nib - c_nib_adj;
    end
  end

endmodule : bcd_nibble_sub3
`default_nettype wire

// File: rtl/bcd_to_binary.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_binary
//  Brief    : Sequential packed-BCD to unsigned binary converter using the
//             reverse double-dabble (shift right, subtract 3) algorithm.
//             Optional feature macro: BCD_DIGIT_CHECK_EN - flags any input
//             digit above 9 on err and finishes without converting.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            rst,     // active low
  input  logic                            start,
  input  logic [c_digit_w*NUM_DIGITS-1:0] bcdin,
  output logic [c_digit_w*NUM_DIGITS-1:0] binout,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int c_w     = c_digit_w * NUM_DIGITS;
  localparam int c_cnt_w = $clog2(c_w + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_w);

  state_t               r_state;
  state_t               w_next;
  logic [2*c_w-1:0]     r_work;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_w-1:0]       r_binout;
  logic                 r_done;
  logic [c_w-1:0]       w_corr;
  logic                 w_err_hold;

  // Digit corrections operate on the BCD half (upper c_w bits) of r_work.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    bcd_nibble_sub3 u_sub3 (
      .i_nib (r_work[c_w + g*c_digit_w +: c_digit_w]),
      .o_nib (w_corr[g*c_digit_w +: c_digit_w])
    );
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic                  r_err;
  logic                  w_bad;
  logic [NUM_DIGITS-1:0] w_digit_bad;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_chk
    assign w_digit_bad[g] = (bcdin[g*c_digit_w +: c_digit_w] > c_max_digit);
  end

  assign w_bad      = |w_digit_bad;
  assign w_err_hold = r_err;
  assign err        = r_err;

  // Error flag: set on an invalid digit at load, cleared by the next accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_err <= 1'b0;
    end else if (r_state == ST_INIT && w_bad) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_err_hold = 1'b0;
  assign err        = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: load, then c_w shift/check pairs, then publish.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = ST_INIT;
`ifdef BCD_DIGIT_CHECK_EN
      ST_INIT:  w_next = w_bad ? ST_DONE : ST_SHIFT;
`else
      ST_INIT:  w_next = ST_SHIFT;
`endif
      ST_SHIFT: w_next = ST_CHECK;
      ST_CHECK: w_next = (r_cnt == c_last) ? ST_DONE : ST_SHIFT;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Datapath: work register, shift counter, result and completion pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_work   <= '0;
      r_cnt    <= '0;
      r_binout <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_INIT: begin
          r_work <= {bcdin, {c_w{1'b0}}};
          r_cnt  <= '0;
        end
        ST_SHIFT: begin
          r_work <= r_work >> 1;
          r_cnt  <= r_cnt + 1'b1;
        end
        ST_CHECK: begin
          r_work[2*c_w-1:c_w] <= w_corr;
        end
        ST_DONE: begin
          // An aborted (invalid-digit) run keeps the previous good result.
          if (!w_err_hold) begin
            r_binout <= r_work[c_w-1:0];
          end
          r_done <= 1'b1;
          r_work <= '0;
          r_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign binout = r_binout;
  assign done   = r_done;
  assign busy   = (r_state != ST_IDLE);

endmodule : bcd_to_binary
`default_nettype wire

// File: tb/tb_bcd_to_binary.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_to_binary
//  Brief    : Directed self-checking bench for bcd_to_binary (4 digits).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bcd_to_binary;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcdin;
  logic [15:0] binout;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  bcd_to_binary #(.NUM_DIGITS(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bcdin  (bcdin),
    .binout (binout),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one conversion and wait (bounded) for done; lat is the edge index
  // of done relative to the start-sampling edge (0 if it never came).
  task automatic convert(input logic [15:0] bcd, output int lat,
                         output bit busy_ok, output bit err_seen);
    lat      = 0;
    busy_ok  = 1'b1;
    err_seen = 1'b0;
    bcdin    = bcd;
    start    = 1'b1;
    tick();
    start = 1'b0;
    if (!busy) busy_ok = 1'b0;
    if (err) err_seen = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      tick();
      if (err) err_seen = 1'b1;
      if (done) begin
        lat = e;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    bcdin = 16'h0000;
    tick();
    tick();
    checks += 4;
    if (binout !== 16'h0000) begin errors++; $display("FAIL reset_binout got %h exp 0000", binout); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_max();
    int lat; bit bok; bit es;
    convert(16'h9999, lat, bok, es);
    checks += 5;
    if (binout !== 16'h270F) begin errors++; $display("FAIL max_value got %h exp 270f", binout); end
    if (lat != 34) begin errors++; $display("FAIL max_latency got %0d exp 34", lat); end
    if (!bok) begin errors++; $display("FAIL max_busy got low exp high throughout"); end
    if (busy !== 1'b0) begin errors++; $display("FAIL max_idle_busy got %b exp 0", busy); end
    tick();
    if (done !== 1'b0) begin errors++; $display("FAIL max_done_pulse got %b exp 0", done); end
    tick();
    checks++;
    if (binout !== 16'h270F) begin errors++; $display("FAIL max_hold got %h exp 270f", binout); end
  endtask

  task automatic test_patterns();
    logic [15:0] vin  [5] = '{16'h0000, 16'h1234, 16'h0010, 16'h0001, 16'h0099};
    logic [15:0] vexp [5] = '{16'h0000, 16'h04D2, 16'h000A, 16'h0001, 16'h0063};
    int lat; bit bok; bit es;
    for (int i = 0; i < 5; i++) begin
      convert(vin[i], lat, bok, es);
      checks += 2;
      if (binout !== vexp[i]) begin errors++; $display("FAIL pattern_%h got %h exp %h", vin[i], binout, vexp[i]); end
      if (lat != 34) begin errors++; $display("FAIL pattern_lat_%h got %0d exp 34", vin[i], lat); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int d[3];
    logic [15:0] v[3];
    int n = 0;
    d = '{0, 0, 0};
    v = '{16'h0, 16'h0, 16'h0};
    bcdin = 16'h1234;
    start = 1'b1;
    tick();
    for (int e = 1; e <= 200 && n < 3; e++) begin
      tick();
      if (done) begin
        d[n] = e;
        v[n] = binout;
        n++;
        bcdin = 16'h0010;
        if (n == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    checks += 5;
    if (d[0] != 34) begin errors++; $display("FAIL b2b_first got %0d exp 34", d[0]); end
    if (d[1] - d[0] != 35) begin errors++; $display("FAIL b2b_gap1 got %0d exp 35", d[1] - d[0]); end
    if (d[2] - d[1] != 35) begin errors++; $display("FAIL b2b_gap2 got %0d exp 35", d[2] - d[1]); end
    if (v[0] !== 16'h04D2) begin errors++; $display("FAIL b2b_val1 got %h exp 04d2", v[0]); end
    if (v[1] !== 16'h000A) begin errors++; $display("FAIL b2b_val2 got %h exp 000a", v[1]); end
    tick();
  endtask

  task automatic test_ignore_start();
    int lat = 0;
    bit extra = 1'b0;
    bcdin = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bcdin = 16'h9999;
    for (int e = 2; e <= 100; e++) begin
      start = (e == 5 || e == 10 || e == 20);
      tick();
      if (done) begin lat = e; break; end
    end
    start = 1'b0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (done || busy) extra = 1'b1;
    end
    checks += 3;
    if (binout !== 16'h04D2) begin errors++; $display("FAIL ignore_value got %h exp 04d2", binout); end
    if (lat != 34) begin errors++; $display("FAIL ignore_latency got %0d exp 34", lat); end
    if (extra) begin errors++; $display("FAIL ignore_requeue got activity exp idle"); end
  endtask

  task automatic test_abort();
    int lat; bit bok; bit es;
    bit spurious = 1'b0;
    bcdin = 16'h9999;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 14; e++) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b exp 1", busy); end
    #2;
    rst = 1'b0;
    #1;
    checks += 4;
    if (binout !== 16'h0000) begin errors++; $display("FAIL abort_binout got %h exp 0000", binout); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done); end
    if (err !== 1'b0) begin errors++; $display("FAIL abort_err got %b exp 0", err); end
    tick();
    tick();
    rst = 1'b1;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (done || busy) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin errors++; $display("FAIL abort_no_done got activity exp idle"); end
    convert(16'h0042, lat, bok, es);
    checks += 2;
    if (binout !== 16'h002A) begin errors++; $display("FAIL abort_next got %h exp 002a", binout); end
    if (lat != 34) begin errors++; $display("FAIL abort_next_lat got %0d exp 34", lat); end
    tick();
  endtask

`ifdef BCD_DIGIT_CHECK_EN
  task automatic test_digit_check();
    int lat; bit bok; bit es;
    convert(16'h1234, lat, bok, es);
    tick();
    bcdin = 16'h12A4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks += 2;
    if (err !== 1'b1) begin errors++; $display("FAIL chk_err_set got %b exp 1", err); end
    if (done !== 1'b0) begin errors++; $display("FAIL chk_done_early got %b exp 0", done); end
    tick();
    checks += 3;
    if (done !== 1'b1) begin errors++; $display("FAIL chk_done got %b exp 1", done); end
    if (binout !== 16'h04D2) begin errors++; $display("FAIL chk_binout got %h exp 04d2", binout); end
    if (err !== 1'b1) begin errors++; $display("FAIL chk_err_hold got %b exp 1", err); end
    tick();
    bcdin = 16'h0042;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL chk_err_clear got %b exp 0", err); end
    for (int e = 1; e <= 100; e++) begin
      tick();
      if (done) break;
    end
    checks++;
    if (binout !== 16'h002A) begin errors++; $display("FAIL chk_next got %h exp 002a", binout); end
    tick();
  endtask
`else
  task automatic test_digit_check();
    int lat; bit bok; bit es;
    convert(16'h12A4, lat, bok, es);
    checks += 2;
    if (es) begin errors++; $display("FAIL nochk_err got 1 exp 0"); end
    if (lat != 34) begin errors++; $display("FAIL nochk_lat got %0d exp 34", lat); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_max();
    test_patterns();
    test_back_to_back();
    test_ignore_start();
    test_abort();
    test_digit_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bcd_to_binary
`default_nettype wire
